socetlib_countdown: RTL and testbench

SOCETLIB_COUNTDOWN -- requirements
Module: socetlib_countdown

---
 rtl/socetlib_countdown_if.sv | 26 ++
 rtl/socetlib_countdown.sv | 94 +++++++++
 tb/tb_socetlib_countdown.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/socetlib_countdown_if.sv
// rtl/socetlib_countdown_if.sv - load/count/expiry signal bundle for socetlib_countdown
interface socetlib_countdown_if #(
  parameter int NBITS = 32
);
  logic             clear;
  logic             load_valid;
  logic             load_ready;
  logic [NBITS-1:0] load_val;
  logic             periodic;
  logic             count_enable;
  logic [NBITS-1:0] count_out;
  logic             busy;
  logic             expire;
  logic             irq;
  logic             irq_clear;

  modport master (
    output clear, load_valid, load_val, periodic, count_enable, irq_clear,
    input  load_ready, count_out, busy, expire, irq
  );

  modport slave (
    input  clear, load_valid, load_val, periodic, count_enable, irq_clear,
    output load_ready, count_out, busy, expire, irq
  );
endinterface

// File: rtl/socetlib_countdown.sv
// rtl/socetlib_countdown.sv - loadable one-shot/periodic down-counter with expire pulse and sticky irq
module socetlib_countdown #(
  parameter int NBITS = 32
) (
  input logic                 CLK,
  input logic                 RST,
  socetlib_countdown_if.slave cif
);
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [NBITS-1:0] ONE  = {{(NBITS-1){1'b0}}, 1'b1};
  localparam logic [NBITS-1:0] ZERO = '0;

  state_t           state, state_n;
  logic [NBITS-1:0] count, count_n;
  logic [NBITS-1:0] reload, reload_n;
  logic             mode, mode_n;
  logic             expire_r, expire_n;
  logic             irq_r, irq_n;
  logic             load_ok;

  assign cif.load_ready = (state == IDLE) && !cif.clear && !RST;
  assign cif.count_out  = count;
  assign cif.busy       = (state == RUN);
  assign cif.expire     = expire_r;
  assign cif.irq        = irq_r;

  assign load_ok = cif.load_valid && cif.load_ready;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      count    <= ZERO;
      reload   <= ZERO;
      mode     <= 1'b0;
      expire_r <= 1'b0;
      irq_r    <= 1'b0;
    end else begin
      state    <= state_n;
      count    <= count_n;
      reload   <= reload_n;
      mode     <= mode_n;
      expire_r <= expire_n;
      irq_r    <= irq_n;
    end
  end

  always_comb begin
    state_n  = state;
    count_n  = count;
    reload_n = reload;
    mode_n   = mode;
    expire_n = 1'b0;
    // expire seen this cycle wins over a coincident clear request
    irq_n    = expire_r ? 1'b1 : (cif.irq_clear ? 1'b0 : irq_r);

    if (cif.clear) begin
      state_n = IDLE;
      count_n = ZERO;
    end else begin
      case (state)
        IDLE: begin
          if (load_ok) begin
            reload_n = cif.load_val;
            mode_n   = cif.periodic;
            count_n  = cif.load_val;
            if (cif.load_val != ZERO) state_n  = RUN;
            else                      expire_n = 1'b1;
          end
        end
        RUN: begin
          if (cif.count_enable) begin
            if (count > ONE) begin
              count_n = count - ONE;
            end else begin
              // terminal count: reload in periodic mode, otherwise stop at zero
              expire_n = 1'b1;
              if (mode) begin
                count_n = reload;
              end else begin
                count_n = ZERO;
                state_n = IDLE;
              end
            end
          end
        end
        default: begin
          state_n = IDLE;
          count_n = ZERO;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_socetlib_countdown.sv
// tb/tb_socetlib_countdown.sv - directed self-checking bench for socetlib_countdown
module tb_socetlib_countdown;
  localparam int NBITS = 8;

  logic CLK = 1'b0;
  logic RST;
  int   n_cmp = 0;
  int   n_err = 0;

  socetlib_countdown_if #(.NBITS(NBITS)) cif ();

  socetlib_countdown #(.NBITS(NBITS)) dut (
    .CLK (CLK),
    .RST (RST),
    .cif (cif.slave)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_st(input string tag, input logic [7:0] cnt, input logic bsy,
                        input logic exp_e, input logic exp_i);
    chk({tag, ".count"},  32'(cif.count_out), 32'(cnt));
    chk({tag, ".busy"},   32'(cif.busy),      32'(bsy));
    chk({tag, ".expire"}, 32'(cif.expire),    32'(exp_e));
    chk({tag, ".irq"},    32'(cif.irq),       32'(exp_i));
  endtask

  initial begin
    RST              = 1'b1;
    cif.clear        = 1'b0;
    cif.load_valid   = 1'b0;
    cif.load_val     = '0;
    cif.periodic     = 1'b0;
    cif.count_enable = 1'b0;
    cif.irq_clear    = 1'b0;

    // reset state
    #1;
    chk_st("rst", 8'd0, 1'b0, 1'b0, 1'b0);
    chk("rst.load_ready", 32'(cif.load_ready), 32'd0);
    tick();
    tick();
    RST = 1'b0;
    #1;
    chk("idle.load_ready", 32'(cif.load_ready), 32'd1);

    // one-shot load 3
    cif.load_valid = 1'b1; cif.load_val = 8'd3; cif.periodic = 1'b0; cif.count_enable = 1'b1;
    tick();
    cif.load_valid = 1'b0;
    chk_st("os3.c3", 8'd3, 1'b1, 1'b0, 1'b0);
    chk("run.load_ready", 32'(cif.load_ready), 32'd0);
    tick(); chk_st("os3.c2", 8'd2, 1'b1, 1'b0, 1'b0);
    tick(); chk_st("os3.c1", 8'd1, 1'b1, 1'b0, 1'b0);
    tick(); chk_st("os3.c0", 8'd0, 1'b0, 1'b1, 1'b0);
    chk("chain.load_ready", 32'(cif.load_ready), 32'd1);

    // chained periodic load 2 in the expire cycle
    cif.load_valid = 1'b1; cif.load_val = 8'd2; cif.periodic = 1'b1;
    tick();
    cif.load_valid = 1'b0;
    chk_st("per.l2", 8'd2, 1'b1, 1'b0, 1'b1);
    cif.count_enable = 1'b1; cif.irq_clear = 1'b1;
    tick(); chk_st("per.e1", 8'd1, 1'b1, 1'b0, 1'b0);
    cif.count_enable = 1'b0; cif.irq_clear = 1'b0;
    tick(); chk_st("per.e0", 8'd1, 1'b1, 1'b0, 1'b0);
    cif.count_enable = 1'b1;
    tick(); chk_st("per.e1b", 8'd2, 1'b1, 1'b1, 1'b0);
    tick(); chk_st("per.e1c", 8'd1, 1'b1, 1'b0, 1'b1);
    tick(); chk_st("per.e1d", 8'd2, 1'b1, 1'b1, 1'b1);

    // irq race: clear coincides with expire
    cif.count_enable = 1'b0; cif.irq_clear = 1'b1;
    tick(); chk_st("irq.race", 8'd2, 1'b1, 1'b0, 1'b1);
    tick(); chk_st("irq.clr", 8'd2, 1'b1, 1'b0, 1'b0);
    cif.irq_clear = 1'b0; cif.clear = 1'b1;
    tick(); chk_st("clr.idle", 8'd0, 1'b0, 1'b0, 1'b0);

    // clear blocks load in IDLE
    cif.load_valid = 1'b1; cif.load_val = 8'd4;
    #1;
    chk("clr.load_ready", 32'(cif.load_ready), 32'd0);
    tick(); chk_st("clr.noload", 8'd0, 1'b0, 1'b0, 1'b0);
    cif.clear = 1'b0;

    // zero load: single expire, stays idle
    cif.load_val = 8'd0; cif.periodic = 1'b1;
    tick();
    cif.load_valid = 1'b0;
    chk_st("zero.l", 8'd0, 1'b0, 1'b1, 1'b0);
    tick(); chk_st("zero.after", 8'd0, 1'b0, 1'b0, 1'b1);

    // unit periodic load: back-to-back expire
    cif.load_valid = 1'b1; cif.load_val = 8'd1; cif.periodic = 1'b1; cif.count_enable = 1'b1;
    cif.irq_clear = 1'b1;
    tick();
    cif.load_valid = 1'b0; cif.irq_clear = 1'b0;
    chk_st("unit.l", 8'd1, 1'b1, 1'b0, 1'b0);
    tick(); chk_st("unit.p1", 8'd1, 1'b1, 1'b1, 1'b0);
    tick(); chk_st("unit.p2", 8'd1, 1'b1, 1'b1, 1'b1);
    tick(); chk_st("unit.p3", 8'd1, 1'b1, 1'b1, 1'b1);
    cif.clear = 1'b1; cif.irq_clear = 1'b1;
    tick(); chk_st("unit.clr", 8'd0, 1'b0, 1'b0, 1'b1);
    cif.clear = 1'b0;
    tick(); chk_st("unit.irq0", 8'd0, 1'b0, 1'b0, 1'b0);
    cif.irq_clear = 1'b0;

    // clear race at count 1 with a pending load
    cif.load_valid = 1'b1; cif.load_val = 8'd3; cif.periodic = 1'b0; cif.count_enable = 1'b1;
    tick();
    cif.load_valid = 1'b0;
    tick();
    tick(); chk_st("race.c1", 8'd1, 1'b1, 1'b0, 1'b0);
    cif.clear = 1'b1; cif.load_valid = 1'b1; cif.load_val = 8'd7;
    tick(); chk_st("race.clr", 8'd0, 1'b0, 1'b0, 1'b0);
    cif.clear = 1'b0; cif.load_valid = 1'b0;
    tick(); chk_st("race.after", 8'd0, 1'b0, 1'b0, 1'b0);

    // load_val changes in RUN are ignored
    cif.load_valid = 1'b1; cif.load_val = 8'd4; cif.count_enable = 1'b0;
    tick();
    cif.load_val = 8'd9;
    chk_st("hold.l4", 8'd4, 1'b1, 1'b0, 1'b0);
    tick(); chk_st("hold.ign", 8'd4, 1'b1, 1'b0, 1'b0);
    cif.load_valid = 1'b0; cif.count_enable = 1'b1;
    tick(); chk_st("hold.dec", 8'd3, 1'b1, 1'b0, 1'b0);
    tick(); tick(); tick();
    chk_st("hold.exp", 8'd0, 1'b0, 1'b1, 1'b0);
    tick();

    // async reset mid-RUN at count 5
    cif.load_valid = 1'b1; cif.load_val = 8'd5; cif.count_enable = 1'b0;
    tick();
    cif.load_valid = 1'b0;
    chk_st("ar.l5", 8'd5, 1'b1, 1'b0, 1'b1);
    #2 RST = 1'b1;
    #1;
    chk_st("ar.rst", 8'd0, 1'b0, 1'b0, 1'b0);
    chk("ar.load_ready", 32'(cif.load_ready), 32'd0);
    #1 RST = 1'b0;
    cif.count_enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("ar.noexp", 32'(cif.expire), 32'd0);
    end
    chk_st("ar.final", 8'd0, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
